// File: rtl/ip_checksum_insert_if.sv
// Word-stream bus with write strobe and ready: the packet-word
// link between pipeline stages.
`timescale 1ns/1ps
interface ip_checksum_insert_if #(
  parameter int DATA_WIDTH = 64,
  parameter int CTRL_WIDTH = DATA_WIDTH / 8
);
  logic [DATA_WIDTH-1:0] data;
  logic [CTRL_WIDTH-1:0] ctrl;
  logic                  wr;
  logic                  rdy;

  modport master (output data, output ctrl, output wr, input rdy);
  modport slave  (input data, input ctrl, input wr, output rdy);
endinterface

// File: rtl/ip_checksum_insert.sv
// Recomputes the IPv4 header checksum of option-less IPv4 packets and writes
// it into word 3; every other word and packet passes through in order.
`timescale 1ns/1ps
module ip_checksum_insert #(
  parameter int DATA_WIDTH = 64,
  parameter int CTRL_WIDTH = DATA_WIDTH / 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    insert_en,
  output logic                    csum_inserted,
  ip_checksum_insert_if.slave     in_bus,
  ip_checksum_insert_if.master    out_bus
);

  localparam int FW = DATA_WIDTH + CTRL_WIDTH;

  typedef enum logic [3:0] {
    MOD_HDRS, WORD0, WORD1, WORD2, HOLD3, HOLD4,
    FOLD1, FOLD2, EMIT3, EMIT4, PAYLOAD
  } state_t;

  // Input FIFO: 8 entries, fall-through head, nearly-full at 6 entries.
  logic [FW-1:0] fifo_mem [8];
  logic [2:0]    wr_ptr_reg;
  logic [2:0]    rd_ptr_reg;
  logic [3:0]    count_reg;
  logic          fifo_push;
  logic          fifo_pop;
  logic          fifo_empty;

  logic [DATA_WIDTH-1:0] head_data;
  logic [CTRL_WIDTH-1:0] head_ctrl;
  logic                  head_eop;
  logic [15:0]           head_half [4];

  assign fifo_empty = (count_reg == 4'd0);
  assign fifo_push  = in_bus.wr && (count_reg != 4'd8);
  assign in_bus.rdy = (count_reg < 4'd6);
  assign head_data  = fifo_mem[rd_ptr_reg][DATA_WIDTH-1:0];
  assign head_ctrl  = fifo_mem[rd_ptr_reg][FW-1:DATA_WIDTH];
  assign head_eop   = (head_ctrl != '0);

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_half
      assign head_half[gi] = head_data[16*gi +: 16];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (fifo_push) begin
      fifo_mem[wr_ptr_reg] <= {in_bus.ctrl, in_bus.data};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (fifo_push) wr_ptr_reg <= wr_ptr_reg + 3'd1;
      if (fifo_pop)  rd_ptr_reg <= rd_ptr_reg + 3'd1;
      if (fifo_push && !fifo_pop)      count_reg <= count_reg + 4'd1;
      else if (!fifo_push && fifo_pop) count_reg <= count_reg - 4'd1;
    end
  end

  // Header checksum state
  state_t        state_reg, state_next;
  logic [19:0]   acc_reg, acc_next;
  logic [FW-1:0] hold_reg, hold_next;
  logic [FW-1:0] hold2_reg, hold2_next;
  logic          en_reg, en_next;
  logic          elig_reg, elig_next;
  logic          modify_reg, modify_next;
  logic          have_w4_reg, have_w4_next;

  logic [19:0] sum_w2;
  logic [19:0] sum_w3;
  logic        hold_eop;
  logic        hold2_eop;
  logic        head_ok;
  logic        fwd_ok;

  assign sum_w2 = 20'(head_half[0]) + 20'(head_half[1]) +
                  20'(head_half[2]) + 20'(head_half[3]);
  assign sum_w3 = 20'(head_half[0]) + 20'(head_half[1]) + 20'(head_half[2]);
  assign hold_eop  = (hold_reg[FW-1:DATA_WIDTH] != '0);
  assign hold2_eop = (hold2_reg[FW-1:DATA_WIDTH] != '0);
  assign head_ok   = !fifo_empty;
  assign fwd_ok    = head_ok && out_bus.rdy;

  function automatic logic [19:0] fold(input logic [19:0] a);
    return 20'(a[15:0]) + 20'(a[19:16]);
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= MOD_HDRS;
      acc_reg     <= '0;
      hold_reg    <= '0;
      hold2_reg   <= '0;
      en_reg      <= 1'b0;
      elig_reg    <= 1'b0;
      modify_reg  <= 1'b0;
      have_w4_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      acc_reg     <= acc_next;
      hold_reg    <= hold_next;
      hold2_reg   <= hold2_next;
      en_reg      <= en_next;
      elig_reg    <= elig_next;
      modify_reg  <= modify_next;
      have_w4_reg <= have_w4_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    acc_next      = acc_reg;
    hold_next     = hold_reg;
    hold2_next    = hold2_reg;
    en_next       = en_reg;
    elig_next     = elig_reg;
    modify_next   = modify_reg;
    have_w4_next  = have_w4_reg;
    fifo_pop      = 1'b0;
    out_bus.wr    = 1'b0;
    out_bus.data  = '0;
    out_bus.ctrl  = '0;
    csum_inserted = 1'b0;

    unique case (state_reg)
      MOD_HDRS: begin
        if (head_ok) begin
          if (head_eop) begin
            if (out_bus.rdy) begin
              fifo_pop     = 1'b1;
              out_bus.wr   = 1'b1;
              out_bus.data = head_data;
              out_bus.ctrl = head_ctrl;
            end
          end else begin
            // First data word seen: start a fresh header sum.
            state_next = WORD0;
            acc_next   = '0;
            en_next    = insert_en;
          end
        end
      end
      WORD0, WORD1, WORD2, PAYLOAD: begin
        if (fwd_ok) begin
          fifo_pop     = 1'b1;
          out_bus.wr   = 1'b1;
          out_bus.data = head_data;
          out_bus.ctrl = head_ctrl;
          if (head_eop) begin
            state_next = MOD_HDRS;
          end else begin
            unique case (state_reg)
              WORD0:   state_next = WORD1;
              WORD1:   state_next = WORD2;
              WORD2:   state_next = HOLD3;
              default: state_next = PAYLOAD;
            endcase
          end
          if (state_reg == WORD1) begin
            elig_next = en_reg && (head_data[31:16] == 16'h0800) &&
                        (head_data[15:8] == 8'h45);
            acc_next  = acc_reg + 20'(head_half[0]);
          end else if (state_reg == WORD2) begin
            acc_next = acc_reg + sum_w2;
          end
        end
      end
      HOLD3: begin
        if (head_ok) begin
          fifo_pop     = 1'b1;
          hold_next    = {head_ctrl, head_data};
          acc_next     = acc_reg + sum_w3;
          have_w4_next = 1'b0;
          if (head_eop || !elig_reg) begin
            modify_next = 1'b0;
            state_next  = EMIT3;
          end else begin
            state_next = HOLD4;
          end
        end
      end
      HOLD4: begin
        if (head_ok) begin
          fifo_pop     = 1'b1;
          hold2_next   = {head_ctrl, head_data};
          acc_next     = acc_reg + 20'(head_half[3]);
          have_w4_next = 1'b1;
          modify_next  = 1'b1;
          state_next   = FOLD1;
        end
      end
      FOLD1: begin
        acc_next   = fold(acc_reg);
        state_next = FOLD2;
      end
      FOLD2: begin
        acc_next   = fold(acc_reg);
        state_next = EMIT3;
      end
      EMIT3: begin
        if (out_bus.rdy) begin
          out_bus.wr    = 1'b1;
          out_bus.ctrl  = hold_reg[FW-1:DATA_WIDTH];
          csum_inserted = modify_reg;
          if (modify_reg) begin
            out_bus.data = {~acc_reg[15:0], hold_reg[DATA_WIDTH-17:0]};
          end else begin
            out_bus.data = hold_reg[DATA_WIDTH-1:0];
          end
          // A non-EOP word 3 of an untouched packet still has payload behind it.
          if (have_w4_reg)   state_next = EMIT4;
          else if (hold_eop) state_next = MOD_HDRS;
          else               state_next = PAYLOAD;
        end
      end
      EMIT4: begin
        if (out_bus.rdy) begin
          out_bus.wr   = 1'b1;
          out_bus.data = hold2_reg[DATA_WIDTH-1:0];
          out_bus.ctrl = hold2_reg[FW-1:DATA_WIDTH];
          state_next   = hold2_eop ? MOD_HDRS : PAYLOAD;
        end
      end
      default: state_next = MOD_HDRS;
    endcase
  end

endmodule

// File: tb/tb_ip_checksum_insert.sv
// Randomised scoreboard bench for ip_checksum_insert: stimulus pushes expected
// words into a queue, a negedge monitor pops and compares emitted words.
`timescale 1ns/1ps
module tb_ip_checksum_insert;
  localparam int DW = 64;
  localparam int CW = 8;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic insert_en = 1'b0;
  logic csum_inserted;

  ip_checksum_insert_if #(.DATA_WIDTH(DW), .CTRL_WIDTH(CW)) in_if ();
  ip_checksum_insert_if #(.DATA_WIDTH(DW), .CTRL_WIDTH(CW)) out_if ();

  ip_checksum_insert #(.DATA_WIDTH(DW), .CTRL_WIDTH(CW)) dut (
    .clk(clk), .reset(reset), .insert_en(insert_en),
    .csum_inserted(csum_inserted), .in_bus(in_if), .out_bus(out_if)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] data;
    logic [7:0]  ctrl;
    logic        csum;
  } exp_t;

  exp_t        exp_q [$];
  logic [63:0] pd [$];
  logic [7:0]  pc [$];
  int total = 0;
  int bad = 0;
  int exp_pulses = 0;
  int seen_pulses = 0;
  int pkt_cnt = 0;
  int rdy_mode = 1;  // 0 = low, 1 = high, 2 = random

  initial begin
    out_if.rdy = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       out_if.rdy = 1'b0;
        1:       out_if.rdy = 1'b1;
        default: out_if.rdy = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (out_if.wr) begin
          total++;
          if (out_if.rdy !== 1'b1) begin
            bad++;
            $display("FAIL wr_without_rdy: out_rdy=%b required 1", out_if.rdy);
          end
          if (csum_inserted === 1'b1) seen_pulses++;
          total++;
          if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL unexpected_word: data=%h ctrl=%h required no word",
                     out_if.data, out_if.ctrl);
          end else begin
            e = exp_q.pop_front();
            if (out_if.data !== e.data || out_if.ctrl !== e.ctrl ||
                csum_inserted !== e.csum) begin
              bad++;
              $display("FAIL word: data=%h ctrl=%h pulse=%b required data=%h ctrl=%h pulse=%b",
                       out_if.data, out_if.ctrl, csum_inserted, e.data, e.ctrl, e.csum);
            end
          end
        end else if (csum_inserted !== 1'b0) begin
          total++;
          bad++;
          $display("FAIL stray_pulse: csum_inserted=%b required 0 with out_wr=0", csum_inserted);
        end
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%h required=%h", name, got, want);
    end
  endtask

  task automatic make_pkt(input int ndata, input logic [15:0] etype, input logic [7:0] vihl);
    logic [63:0] w;
    logic [7:0]  eop;
    pd.delete();
    pc.delete();
    pd.push_back({$urandom(), $urandom()});
    pc.push_back(8'hff);
    for (int k = 0; k < ndata; k++) begin
      w = {$urandom(), $urandom()};
      if (k == 1) begin
        w[31:16] = etype;
        w[15:8]  = vihl;
      end
      eop = 8'h01;
      eop = eop << $urandom_range(0, 7);
      pd.push_back(w);
      pc.push_back((k == ndata - 1) ? eop : 8'h00);
    end
  endtask

  // Reference: RFC 1071 sum over the ten header halfwords, checksum field as zero.
  function automatic logic [15:0] ref_csum();
    logic [15:0] h [10];
    logic [31:0] s;
    h[0] = pd[2][15:0];
    h[1] = pd[3][63:48];
    h[2] = pd[3][47:32];
    h[3] = pd[3][31:16];
    h[4] = pd[3][15:0];
    h[5] = 16'h0000;
    h[6] = pd[4][47:32];
    h[7] = pd[4][31:16];
    h[8] = pd[4][15:0];
    h[9] = pd[5][63:48];
    s = 0;
    for (int i = 0; i < 10; i++) s = s + 32'(h[i]);
    while ((s >> 16) != 0) s = (s & 32'h0000_ffff) + (s >> 16);
    return ~s[15:0];
  endfunction

  task automatic send_word(input logic [63:0] d, input logic [7:0] c);
    int guard = 0;
    while (in_if.rdy !== 1'b1 && guard < 2000) begin
      @(posedge clk);
      #1;
      guard++;
    end
    if (guard >= 2000) begin
      total++;
      bad++;
      $display("FAIL in_rdy_timeout: in_rdy=%b required 1 within 2000 cycles", in_if.rdy);
    end
    in_if.data = d;
    in_if.ctrl = c;
    in_if.wr   = 1'b1;
    @(posedge clk);
    #1;
    in_if.wr   = 1'b0;
  endtask

  task automatic send_pkt(input bit en, input bit fixed, input logic [15:0] fixed_csum);
    int nd;
    bit elig;
    logic [15:0] cs;
    exp_t e;
    nd = pd.size() - 1;
    elig = en && nd >= 5 && pd[2][31:16] == 16'h0800 && pd[2][15:8] == 8'h45;
    cs = 16'h0000;
    if (elig) cs = fixed ? fixed_csum : ref_csum();
    for (int i = 0; i < pd.size(); i++) begin
      e.data = pd[i];
      e.ctrl = pc[i];
      e.csum = 1'b0;
      if (elig && i == 4) begin
        e.data[63:48] = cs;
        e.csum = 1'b1;
      end
      exp_q.push_back(e);
    end
    if (elig) exp_pulses++;
    pkt_cnt++;
    $display("pkt %0d: data_words=%0d eligible=%0b csum=%h", pkt_cnt, nd, elig, cs);
    for (int i = 0; i < pd.size(); i++) send_word(pd[i], pc[i]);
  endtask

  task automatic drain();
    int g = 0;
    while (exp_q.size() != 0 && g < 8000) begin
      @(posedge clk);
      g++;
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain_timeout: remaining=%0d required 0", exp_q.size());
    end
    repeat (5) @(posedge clk);
    #1;
  endtask

  initial begin
    int g;
    logic [15:0] et;
    logic [7:0]  vi;
    in_if.data = '0;
    in_if.ctrl = '0;
    in_if.wr   = 1'b0;
    rdy_mode   = 1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    @(negedge clk);
    check("reset_out_wr", 64'(out_if.wr), 64'd0);
    check("reset_out_data", out_if.data, 64'd0);
    check("reset_out_ctrl", 64'(out_if.ctrl), 64'd0);
    check("reset_csum_inserted", 64'(csum_inserted), 64'd0);
    check("reset_in_rdy", 64'(in_if.rdy), 64'd1);
    @(posedge clk);
    #1;

    // Known-answer header, then same header with a stale checksum.
    insert_en = 1'b1;
    make_pkt(8, 16'h0800, 8'h45);
    pd[2][15:0] = 16'h4500;
    pd[3] = 64'h0073_0000_4000_4011;
    pd[4] = {16'h0000, 48'hc0a8_0001_c0a8};
    pd[5][63:48] = 16'h00c7;
    send_pkt(1'b1, 1'b1, 16'hb861);
    pd[4][63:48] = 16'hffff;
    send_pkt(1'b1, 1'b1, 16'hb861);
    drain();

    // Ineligible: ARP, IHL with options, insert disabled.
    make_pkt(7, 16'h0806, 8'h45);
    send_pkt(1'b1, 1'b0, 16'h0);
    make_pkt(7, 16'h0800, 8'h46);
    send_pkt(1'b1, 1'b0, 16'h0);
    drain();
    insert_en = 1'b0;
    make_pkt(7, 16'h0800, 8'h45);
    send_pkt(1'b0, 1'b0, 16'h0);
    drain();
    insert_en = 1'b1;

    // Short packets back to back with full ones.
    make_pkt(3, 16'h0800, 8'h45);
    send_pkt(1'b1, 1'b0, 16'h0);
    make_pkt(6, 16'h0800, 8'h45);
    send_pkt(1'b1, 1'b0, 16'h0);
    make_pkt(4, 16'h0800, 8'h45);
    send_pkt(1'b1, 1'b0, 16'h0);
    make_pkt(5, 16'h0800, 8'h45);
    send_pkt(1'b1, 1'b0, 16'h0);
    make_pkt(1, 16'h0800, 8'h45);
    send_pkt(1'b1, 1'b0, 16'h0);
    drain();

    // 100 eligible packets under random backpressure, then a random mix.
    rdy_mode = 2;
    for (int p = 0; p < 100; p++) begin
      make_pkt($urandom_range(5, 12), 16'h0800, 8'h45);
      send_pkt(1'b1, 1'b0, 16'h0);
    end
    for (int p = 0; p < 30; p++) begin
      case ($urandom_range(0, 2))
        0:       et = 16'h0800;
        1:       et = 16'h0806;
        default: et = 16'h86dd;
      endcase
      vi = ($urandom_range(0, 3) == 0) ? 8'h46 : 8'h45;
      make_pkt($urandom_range(1, 9), et, vi);
      send_pkt(1'b1, 1'b0, 16'h0);
    end
    drain();

    // Reset while the checksum is being folded.
    rdy_mode = 0;
    make_pkt(5, 16'h0800, 8'h45);
    send_pkt(1'b1, 1'b0, 16'h0);
    rdy_mode = 1;
    g = 0;
    while (g < 200) begin
      @(posedge clk);
      if (exp_q.size() == 2) break;
      g++;
    end
    total++;
    if (g >= 200) begin
      bad++;
      $display("FAIL fold_sync_timeout: remaining=%0d required 2", exp_q.size());
    end
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    exp_pulses--;
    @(posedge clk);
    #1 reset = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check("post_reset_out_wr", 64'(out_if.wr), 64'd0);
    check("post_reset_csum_inserted", 64'(csum_inserted), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    make_pkt(6, 16'h0800, 8'h45);
    send_pkt(1'b1, 1'b0, 16'h0);
    drain();

    check("csum_pulse_count", 64'(seen_pulses), 64'(exp_pulses));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
